// File: rtl/timerio_pkg.sv
// timerio_pkg
//   Shared definitions for the timerio dual interval timer: register
//   address map, CTRL/STAT bit positions and the counter width.
//   Optional feature macro used by the design: TIMERIO_CAPTURE_EN.
package timerio_pkg;

  localparam int CNT_W = 16;

  // Register addresses (AD[3:0])
  localparam logic [3:0] A_CTRL     = 4'h0;
  localparam logic [3:0] A_STAT     = 4'h1;
  localparam logic [3:0] A_PRESC    = 4'h2;
  localparam logic [3:0] A_RELOAD0H = 4'h4;
  localparam logic [3:0] A_RELOAD0L = 4'h5;
  localparam logic [3:0] A_COUNT0H  = 4'h6;
  localparam logic [3:0] A_COUNT0L  = 4'h7;
  localparam logic [3:0] A_RELOAD1H = 4'h8;
  localparam logic [3:0] A_RELOAD1L = 4'h9;
  localparam logic [3:0] A_COUNT1H  = 4'hA;
  localparam logic [3:0] A_COUNT1L  = 4'hB;
  localparam logic [3:0] A_CAPH     = 4'hC;
  localparam logic [3:0] A_CAPL     = 4'hD;

  // CTRL bit positions
  localparam int CTRL_EN0   = 0;
  localparam int CTRL_AUTO0 = 1;
  localparam int CTRL_IE0   = 2;
  localparam int CTRL_CIE   = 3;
  localparam int CTRL_EN1   = 4;
  localparam int CTRL_AUTO1 = 5;
  localparam int CTRL_IE1   = 6;

  // STAT bit positions
  localparam int STAT_TF0 = 0;
  localparam int STAT_TF1 = 1;
  localparam int STAT_CF  = 2;

endpackage

// File: rtl/timerio_chan.sv
// timerio_chan
//   One 16-bit down-counting timer channel.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     en         channel enable (CTRL ENn as currently registered)
//     en_rise    CPU write turning ENn from 0 to 1 this cycle
//     auto       auto-reload mode (CTRL AUTOn)
//     tick       shared prescaler tick
//     reload     RELOADn value
//     count      current COUNTn
//     terminal   one-cycle pulse: tick seen while count == 0 (sets TFn)
//     en_clr     request to clear ENn (terminal in one-shot mode)
module timerio_chan
  import timerio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             en_rise,
  input  logic             auto,
  input  logic             tick,
  input  logic [CNT_W-1:0] reload,
  output logic [CNT_W-1:0] count,
  output logic             terminal,
  output logic             en_clr
);

  // A load on the enable edge takes priority over a coincident tick.
  assign terminal = en && tick && !en_rise && (count == '0);
  assign en_clr   = terminal && !auto;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en_rise) begin
      count <= reload;
    end else if (en && tick) begin
      if (count != '0)
        count <= count - CNT_W'(1);
      else if (auto)
        count <= reload;
      // one-shot terminal: count holds at 0
    end
  end

endmodule

// File: rtl/timerio.sv
// timerio
//   Memory-mapped dual 16-bit interval timer for the 6801 system bus.
//   Two channels share an 8-bit prescaler; a level IRQ is raised from the
//   enabled status flags. Optional input capture (macro TIMERIO_CAPTURE_EN)
//   timestamps a rising edge of cap_in against COUNT0.
//   Ports:
//     clk     bus clock
//     rst     asynchronous active-low reset
//     AD      register address
//     DI      write data
//     DO      read data, combinational from AD
//     rw      1 = read, 0 = write
//     cs      chip select
//     cap_in  asynchronous capture input (only with TIMERIO_CAPTURE_EN)
//     irq     level interrupt request, active-high
//   Bus transfer: one access per clk in which cs is high; rw selects
//   direction. Writes and read side effects (shadow latch) take effect on
//   that rising clk edge; there is no wait state or backpressure.
module timerio
  import timerio_pkg::*;
#(
  parameter logic [7:0] PRESC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
`ifdef TIMERIO_CAPTURE_EN
  input  logic       cap_in,
`endif
  output logic       irq
);

`ifdef TIMERIO_CAPTURE_EN
  localparam logic [6:0] CTRL_WMASK = 7'h7F;
`else
  localparam logic [6:0] CTRL_WMASK = 7'h77;
`endif

  logic             wr, rd, ctrl_wr, stat_wr;
  logic [6:0]       ctrl_q, ctrl_d;
  logic [7:0]       presc_q, presc_cnt, temp_q, shadow_q;
  logic [CNT_W-1:0] reload0_q, reload1_q, count0, count1;
  logic             tf0_q, tf1_q, cf_q;
  logic             run, tick;
  logic             en_rise0, en_rise1, term0, term1, en_clr0, en_clr1;

  assign wr      = cs && !rw;
  assign rd      = cs && rw;
  assign ctrl_wr = wr && (AD == A_CTRL);
  assign stat_wr = wr && (AD == A_STAT);

  assign en_rise0 = ctrl_wr && DI[CTRL_EN0] && !ctrl_q[CTRL_EN0];
  assign en_rise1 = ctrl_wr && DI[CTRL_EN1] && !ctrl_q[CTRL_EN1];

  // A one-shot terminal clears EN even if the CPU writes CTRL that cycle.
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = DI[6:0] & CTRL_WMASK;
    if (en_clr0) ctrl_d[CTRL_EN0] = 1'b0;
    if (en_clr1) ctrl_d[CTRL_EN1] = 1'b0;
  end

  // Prescaler: held at 0 while both channels are off, so the first tick
  // comes PRESC+1 clocks after the enabling write.
  assign run  = ctrl_q[CTRL_EN0] || ctrl_q[CTRL_EN1];
  assign tick = run && (presc_cnt == presc_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc_cnt <= '0;
    else if (!run || tick)
      presc_cnt <= '0;
    else
      presc_cnt <= presc_cnt + 8'd1;
  end

`ifdef TIMERIO_CAPTURE_EN
  // 2-FF synchronizer (s1, s2), edge register (s3) and a registered edge
  // pulse; CAPTURE/CF update three clocks after cap_in is first sampled.
  logic             cap_s1, cap_s2, cap_s3, cap_hit;
  logic [CNT_W-1:0] cap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_s1  <= 1'b0;
      cap_s2  <= 1'b0;
      cap_s3  <= 1'b0;
      cap_hit <= 1'b0;
      cap_q   <= '0;
      cf_q    <= 1'b0;
    end else begin
      cap_s1  <= cap_in;
      cap_s2  <= cap_s1;
      cap_s3  <= cap_s2;
      cap_hit <= cap_s2 && !cap_s3;
      if (cap_hit) cap_q <= count0;
      cf_q    <= (cf_q && !(stat_wr && DI[STAT_CF])) || cap_hit;
    end
  end
`else
  assign cf_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      presc_q   <= PRESC_RESET;
      temp_q    <= '0;
      shadow_q  <= '0;
      reload0_q <= '0;
      reload1_q <= '0;
      tf0_q     <= 1'b0;
      tf1_q     <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      // A set in the same cycle as a write-1-clear wins.
      tf0_q  <= (tf0_q && !(stat_wr && DI[STAT_TF0])) || term0;
      tf1_q  <= (tf1_q && !(stat_wr && DI[STAT_TF1])) || term1;
      if (wr) begin
        case (AD)
          A_PRESC:                presc_q   <= DI;
          A_RELOAD0H, A_RELOAD1H: temp_q    <= DI;
          A_RELOAD0L:             reload0_q <= {temp_q, DI};
          A_RELOAD1L:             reload1_q <= {temp_q, DI};
          default: ;
        endcase
      end
      if (rd) begin
        case (AD)
          A_COUNT0H: shadow_q <= count0[7:0];
          A_COUNT1H: shadow_q <= count1[7:0];
`ifdef TIMERIO_CAPTURE_EN
          A_CAPH:    shadow_q <= cap_q[7:0];
`endif
          default: ;
        endcase
      end
    end
  end

  timerio_chan u_chan0 (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q[CTRL_EN0]),
    .en_rise  (en_rise0),
    .auto     (ctrl_q[CTRL_AUTO0]),
    .tick     (tick),
    .reload   (reload0_q),
    .count    (count0),
    .terminal (term0),
    .en_clr   (en_clr0)
  );

  timerio_chan u_chan1 (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q[CTRL_EN1]),
    .en_rise  (en_rise1),
    .auto     (ctrl_q[CTRL_AUTO1]),
    .tick     (tick),
    .reload   (reload1_q),
    .count    (count1),
    .terminal (term1),
    .en_clr   (en_clr1)
  );

  always_comb begin
    DO = '0;
    case (AD)
      A_CTRL:     DO = {1'b0, ctrl_q};
      A_STAT:     DO = {5'b0, cf_q, tf1_q, tf0_q};
      A_PRESC:    DO = presc_q;
      A_RELOAD0H: DO = reload0_q[15:8];
      A_RELOAD0L: DO = reload0_q[7:0];
      A_COUNT0H:  DO = count0[15:8];
      A_COUNT0L:  DO = shadow_q;
      A_RELOAD1H: DO = reload1_q[15:8];
      A_RELOAD1L: DO = reload1_q[7:0];
      A_COUNT1H:  DO = count1[15:8];
      A_COUNT1L:  DO = shadow_q;
`ifdef TIMERIO_CAPTURE_EN
      A_CAPH:     DO = cap_q[15:8];
      A_CAPL:     DO = shadow_q;
`endif
      default:    DO = '0;
    endcase
  end

`ifdef TIMERIO_CAPTURE_EN
  assign irq = (tf0_q && ctrl_q[CTRL_IE0]) || (tf1_q && ctrl_q[CTRL_IE1]) ||
               (cf_q && ctrl_q[CTRL_CIE]);
`else
  assign irq = (tf0_q && ctrl_q[CTRL_IE0]) || (tf1_q && ctrl_q[CTRL_IE1]);
`endif

endmodule

// File: tb/tb_timerio.sv
// tb_timerio
//   Bench for timerio. Bus tasks drive the DUT just after the rising edge;
//   expected read data / irq levels are queued when each access is issued
//   and a monitor compares them on the falling edge. Counter behaviour is
//   predicted from elapsed clock counts with plain arithmetic.
module tb_timerio;
  import timerio_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] AD  = 4'h0;
  logic [7:0] DI  = 8'h00;
  logic [7:0] DO;
  logic       rw  = 1'b1;
  logic       cs  = 1'b0;
  logic       irq;
`ifdef TIMERIO_CAPTURE_EN
  logic       cap_in = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  timerio #(.PRESC_RESET(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .AD     (AD),
    .DI     (DI),
    .DO     (DO),
    .rw     (rw),
    .cs     (cs),
`ifdef TIMERIO_CAPTURE_EN
    .cap_in (cap_in),
`endif
    .irq    (irq)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       irq_exp_q[$];
  string      irq_name_q[$];
  logic       irq_chk = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] mon_exp;
  logic       mon_irq;
  string      mon_name;

  always @(negedge clk) begin
    if (cs && rw) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: DO=%02h with nothing queued", DO);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checks++;
        if (DO !== mon_exp) begin
          errors++;
          $display("FAIL %s: DO=%02h expected %02h (cyc %0d)", mon_name, DO, mon_exp, cyc);
        end
      end
    end
    if (irq_chk) begin
      if (irq_exp_q.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected: irq check with nothing queued");
      end else begin
        mon_irq  = irq_exp_q.pop_front();
        mon_name = irq_name_q.pop_front();
        checks++;
        if (irq !== mon_irq) begin
          errors++;
          $display("FAIL %s: irq=%0b expected %0b (cyc %0d)", mon_name, irq, mon_irq, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) begin
      checks++;
      errors++;
      $display("FAIL schedule: cyc=%0d already past target %0d", cyc, t);
    end
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    cs = 1'b1; rw = 1'b1; AD = a;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string n);
    irq_exp_q.push_back(e);
    irq_name_q.push_back(n);
    irq_chk = 1'b1;
    @(posedge clk);
    #1;
    irq_chk = 1'b0;
  endtask

  task automatic wr16(input logic [3:0] ah, input int v);
    bus_wr(ah, 8'(v >> 8));
    bus_wr(ah + 4'h1, 8'(v));
  endtask

  // ---------------- reference model ----------------
  // Channel enabled (with the prescaler starting from rest) at edge e.
  // Ticks land every p+1 edges after e.
  function automatic int ch_ticks(input int n, input int e, input int p);
    if (n < e) return 0;
    return (n - e) / (p + 1);
  endfunction

  // COUNT after edge n
  function automatic int ch_count(input int n, input int e, input int p,
                                  input int r, input bit a);
    int t;
    t = ch_ticks(n, e, p);
    if (a) return r - (t % (r + 1));
    return (t >= r) ? 0 : r - t;
  endfunction

  // TF has been set by edge n (first time the count is seen at zero on a tick)
  function automatic bit ch_fired(input int n, input int e, input int p, input int r);
    return ch_ticks(n, e, p) >= r + 1;
  endfunction

  // ---------------- stimulus ----------------
  int e_cyc, n_cyc, v, v1;
  int p, r0, r1;
  bit a0, a1, ie0, ie1, f0, f1, en0, en1;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    chk_irq(1'b0, "reset_irq");
    for (int a = 0; a < 16; a++) bus_rd(4'(a), 8'h00, $sformatf("reset_reg%0h", a));

    // Register sanity, reserved addresses, CTRL masks
    bus_wr(A_PRESC, 8'hA5);
    bus_rd(A_PRESC, 8'hA5, "presc_rw");
    bus_wr(A_CTRL, 8'h88);
`ifdef TIMERIO_CAPTURE_EN
    bus_rd(A_CTRL, 8'h08, "ctrl_mask");
`else
    bus_rd(A_CTRL, 8'h00, "ctrl_mask");
`endif
    bus_wr(A_CTRL, 8'h00);
    bus_wr(4'h3, 8'hFF);
    bus_rd(4'h3, 8'h00, "reserved_3");
    bus_rd(4'hE, 8'h00, "reserved_e");
    bus_rd(4'hF, 8'h00, "reserved_f");
    bus_wr(A_STAT, 8'h04);
    bus_rd(A_STAT, 8'h00, "stat_idle");

    // One-shot: PRESC=3, RELOAD0=9 -> TF0/irq 40 clk after enable
    bus_wr(A_PRESC, 8'd3);
    wr16(A_RELOAD0H, 9);
    bus_wr(A_CTRL, 8'h05);
    e_cyc = cyc;
    wait_until(e_cyc + 39);
    chk_irq(1'b0, "oneshot_irq_early");
    chk_irq(1'b1, "oneshot_irq_at40");
    bus_rd(A_STAT, 8'h01, "oneshot_stat");
    bus_rd(A_CTRL, 8'h04, "oneshot_en_cleared");
    bus_rd(A_COUNT0H, 8'h00, "oneshot_count0h");
    bus_rd(A_COUNT0L, 8'h00, "oneshot_count0l");
    bus_wr(A_STAT, 8'h00);
    bus_rd(A_STAT, 8'h01, "stat_write0_noeffect");
    bus_wr(A_STAT, 8'h01);
    chk_irq(1'b0, "oneshot_w1c_irq");
    bus_wr(A_CTRL, 8'h00);

    // Auto-reload: PRESC=0, RELOAD1=4 -> TF1 every 5 clk; W1C; set wins
    bus_wr(A_PRESC, 8'd0);
    wr16(A_RELOAD1H, 4);
    bus_wr(A_CTRL, 8'h70);
    e_cyc = cyc;
    wait_until(e_cyc + 4);
    chk_irq(1'b0, "auto_irq_before");
    chk_irq(1'b1, "auto_irq_set");
    bus_wr(A_STAT, 8'h02);
    chk_irq(1'b0, "auto_w1c_drop");
    wait_until(e_cyc + 9);
    bus_wr(A_STAT, 8'h02);
    chk_irq(1'b1, "auto_set_wins_irq");
    bus_rd(A_STAT, 8'h02, "auto_set_wins_stat");
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_STAT, 8'h07);
    chk_irq(1'b0, "auto_stopped_irq");

    // Atomic read of COUNT0 while counting every clk
    wr16(A_RELOAD0H, 16'h0305);
    bus_wr(A_CTRL, 8'h01);
    e_cyc = cyc;
    wait_until(e_cyc + 6);
    n_cyc = cyc;
    v = ch_count(n_cyc, e_cyc, 0, 16'h0305, 1'b0);
    bus_rd(A_COUNT0H, 8'(v >> 8), "atomic_rd_high");
    tick_wait(3);
    bus_rd(A_COUNT0L, 8'(v), "atomic_rd_low_shadow");
    n_cyc = cyc;
    v = ch_count(n_cyc, e_cyc, 0, 16'h0305, 1'b0);
    bus_rd(A_COUNT0H, 8'(v >> 8), "atomic_rd_high_live");
    bus_wr(A_CTRL, 8'h00);

    // Atomic write: temp is shared between RELOAD0H and RELOAD1L
    bus_wr(A_RELOAD0H, 8'h12);
    bus_wr(A_RELOAD1L, 8'h34);
    bus_rd(A_RELOAD1H, 8'h12, "atomic_wr_r1h");
    bus_rd(A_RELOAD1L, 8'h34, "atomic_wr_r1l");
    bus_rd(A_RELOAD0H, 8'h03, "atomic_wr_r0h_kept");
    bus_rd(A_RELOAD0L, 8'h05, "atomic_wr_r0l_kept");

    // Randomized trials against the arithmetic model
    for (int t = 0; t < 16; t++) begin
      p   = $urandom_range(0, 3);
      r0  = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 270) : $urandom_range(0, 20);
      r1  = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 270) : $urandom_range(0, 20);
      a0  = 1'($urandom_range(0, 1));
      a1  = 1'($urandom_range(0, 1));
      ie0 = 1'($urandom_range(0, 1));
      ie1 = 1'($urandom_range(0, 1));
      bus_wr(A_CTRL, 8'h00);
      tick_wait(2);
      bus_wr(A_STAT, 8'h07);
      bus_wr(A_PRESC, 8'(p));
      wr16(A_RELOAD0H, r0);
      wr16(A_RELOAD1H, r1);
      bus_wr(A_CTRL, {1'b0, ie1, a1, 1'b1, 1'b0, ie0, a0, 1'b1});
      e_cyc = cyc;
      tick_wait($urandom_range(0, 70));

      n_cyc = cyc;
      v = ch_count(n_cyc, e_cyc, p, r0, a0);
      bus_rd(A_COUNT0H, 8'(v >> 8), $sformatf("rnd%0d_count0h", t));
      bus_rd(A_COUNT0L, 8'(v), $sformatf("rnd%0d_count0l", t));
      n_cyc = cyc;
      v1 = ch_count(n_cyc, e_cyc, p, r1, a1);
      bus_rd(A_COUNT1H, 8'(v1 >> 8), $sformatf("rnd%0d_count1h", t));
      bus_rd(A_COUNT1L, 8'(v1), $sformatf("rnd%0d_count1l", t));

      n_cyc = cyc;
      f0 = ch_fired(n_cyc, e_cyc, p, r0);
      f1 = ch_fired(n_cyc, e_cyc, p, r1);
      bus_rd(A_STAT, {6'b0, f1, f0}, $sformatf("rnd%0d_stat", t));
      n_cyc = cyc;
      f0  = ch_fired(n_cyc, e_cyc, p, r0);
      f1  = ch_fired(n_cyc, e_cyc, p, r1);
      en0 = a0 || !f0;
      en1 = a1 || !f1;
      bus_rd(A_CTRL, {1'b0, ie1, a1, en1, 1'b0, ie0, a0, en0}, $sformatf("rnd%0d_ctrl", t));
      n_cyc = cyc;
      f0 = ch_fired(n_cyc, e_cyc, p, r0);
      f1 = ch_fired(n_cyc, e_cyc, p, r1);
      chk_irq((f0 && ie0) || (f1 && ie1), $sformatf("rnd%0d_irq", t));
    end
    bus_wr(A_CTRL, 8'h00);
    tick_wait(2);
    bus_wr(A_STAT, 8'h07);

    // Reset mid-count
    bus_wr(A_PRESC, 8'd0);
    wr16(A_RELOAD0H, 16'h0200);
    bus_wr(A_CTRL, 8'h05);
    e_cyc = cyc;
    wait_until(e_cyc + 256);
    bus_rd(A_COUNT0H, 8'h01, "midcount_before_reset");
    rst = 1'b0;
    bus_rd(A_COUNT0H, 8'h00, "in_reset_count0h");
    bus_rd(A_CTRL, 8'h00, "in_reset_ctrl");
    chk_irq(1'b0, "in_reset_irq");
    rst = 1'b1;
    for (int a = 0; a < 16; a++) bus_rd(4'(a), 8'h00, $sformatf("post_reset_reg%0h", a));
    tick_wait(10);
    bus_rd(A_COUNT0H, 8'h00, "post_reset_idle_h");
    bus_rd(A_CTRL, 8'h00, "post_reset_idle_ctrl");
    chk_irq(1'b0, "post_reset_irq");

`ifdef TIMERIO_CAPTURE_EN
    // Capture: cap_in first sampled while COUNT0 == 0xFF00
    wr16(A_RELOAD0H, 16'hFFFF);
    bus_wr(A_CTRL, 8'h0B);
    e_cyc = cyc;
    wait_until(e_cyc + 255);
    cap_in = 1'b1;
    wait_until(e_cyc + 258);
    chk_irq(1'b0, "cap_irq_before");
    chk_irq(1'b1, "cap_irq_set");
    cap_in = 1'b0;
    bus_rd(A_STAT, 8'h04, "cap_stat_cf");
    bus_rd(A_CAPH, 8'hFE, "cap_high");
    bus_rd(A_CAPL, 8'hFD, "cap_low");
    bus_wr(A_STAT, 8'h04);
    chk_irq(1'b0, "cap_w1c_irq");
    bus_wr(A_CTRL, 8'h00);
`endif

    tick_wait(3);
    if (exp_q.size() != 0 || irq_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d reads and %0d irq checks never compared",
               exp_q.size(), irq_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
